// File: rtl/bcd_field_counter.sv
// Multi-digit BCD up/down counter for one time field (seconds, minutes or hours).
// Wraps within [MIN_VAL, MAX_VAL], accepts validated loads, and emits same-cycle carry/borrow for chaining.
module bcd_field_counter #(
   parameter int NUM_DIGITS = 2,
   parameter int MIN_VAL    = 0,
   parameter int MAX_VAL    = 59,
   parameter int RESET_VAL  = 0
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    inc,
   input  logic                    dec,
   input  logic                    set,
   input  logic [4*NUM_DIGITS-1:0] new_val,
   output logic [4*NUM_DIGITS-1:0] Q,
   output logic                    at_max,
   output logic                    at_min,
   output logic                    carry,
   output logic                    borrow,
   output logic                    set_err
);

   localparam int W = 4*NUM_DIGITS;

   if (NUM_DIGITS < 1 || MIN_VAL < 0 || MIN_VAL >= MAX_VAL || MAX_VAL >= 10**NUM_DIGITS) begin : g_bad_range
      $error("bcd_field_counter: need 0 <= MIN_VAL < MAX_VAL < 10**NUM_DIGITS");
   end
   if (RESET_VAL < MIN_VAL || RESET_VAL > MAX_VAL) begin : g_bad_reset
      $error("bcd_field_counter: RESET_VAL must lie in [MIN_VAL, MAX_VAL]");
   end

   function automatic logic [W-1:0] to_bcd(input int v);
      logic [W-1:0] r;
      int           t;
      r = '0;
      t = v;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         r[4*i +: 4] = 4'(t % 10);
         t           = t / 10;
      end
      return r;
   endfunction

   localparam logic [W-1:0] MIN_BCD   = to_bcd(MIN_VAL);
   localparam logic [W-1:0] MAX_BCD   = to_bcd(MAX_VAL);
   localparam logic [W-1:0] RESET_BCD = to_bcd(RESET_VAL);

   // Ripple a +1 through the digits: a 9 rolls to 0 and passes the carry on.
   function automatic logic [W-1:0] bcd_inc(input logic [W-1:0] v);
      logic [W-1:0] r;
      logic         c;
      r = v;
      c = 1'b1;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (c) begin
            if (v[4*i +: 4] == 4'd9) begin
               r[4*i +: 4] = 4'd0;
            end else begin
               r[4*i +: 4] = v[4*i +: 4] + 4'd1;
               c           = 1'b0;
            end
         end
      end
      return r;
   endfunction

   function automatic logic [W-1:0] bcd_dec(input logic [W-1:0] v);
      logic [W-1:0] r;
      logic         b;
      r = v;
      b = 1'b1;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (b) begin
            if (v[4*i +: 4] == 4'd0) begin
               r[4*i +: 4] = 4'd9;
            end else begin
               r[4*i +: 4] = v[4*i +: 4] - 4'd1;
               b           = 1'b0;
            end
         end
      end
      return r;
   endfunction

   logic           digits_ok;
   logic           load_ok;
   logic [W-1:0]   up_next;
   logic [W-1:0]   down_next;

   // NOTE: every variable written here gets a default first so no latch is inferred.
   always_comb begin
      digits_ok = 1'b1;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (new_val[4*i +: 4] > 4'd9) digits_ok = 1'b0;
      end
      // With all digits <= 9, unsigned order of the packed BCD word equals decimal order.
      load_ok   = digits_ok && (new_val >= MIN_BCD) && (new_val <= MAX_BCD);
      up_next   = at_max ? MIN_BCD : bcd_inc(Q);
      down_next = at_min ? MAX_BCD : bcd_dec(Q);
   end

   assign at_max = (Q == MAX_BCD);
   assign at_min = (Q == MIN_BCD);
   assign carry  = inc & ~dec & at_max & ~set & ~reset;
   assign borrow = dec & ~inc & at_min & ~set & ~reset;

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk) begin
      if (reset) begin
         Q       <= RESET_BCD;
         set_err <= 1'b0;
      end else if (set) begin
         set_err <= ~load_ok;
         if (load_ok) Q <= new_val;
      end else begin
         set_err <= 1'b0;
         if (inc && !dec)      Q <= up_next;
         else if (dec && !inc) Q <= down_next;
      end
   end

endmodule

// File: tb/tb_bcd_field_counter.sv
// Randomised and directed bench for bcd_field_counter against a decimal-integer reference model.
// Covers the 0..59 field, a 1..12 hours field and a chained seconds->minutes pair.
module tb_bcd_field_counter;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Field A: 0..59, reset 0
   logic       a_reset, a_inc, a_dec, a_set;
   logic [7:0] a_nv, a_q;
   logic       a_max, a_min, a_cy, a_bw, a_err;
   // Field B: 12-hour hours, 1..12, reset 12
   logic       b_reset, b_inc, b_dec, b_set;
   logic [7:0] b_nv, b_q;
   logic       b_max, b_min, b_cy, b_bw, b_err;
   // Chain: seconds -> minutes, shared reset
   logic       c_reset, s_inc, s_dec, s_set, m_set;
   logic [7:0] s_nv, m_nv, s_q, m_q;
   logic       s_max, s_min, s_cy, s_bw, s_err;
   logic       m_max, m_min, m_cy, m_bw, m_err;

   bcd_field_counter #(.NUM_DIGITS(2), .MIN_VAL(0), .MAX_VAL(59), .RESET_VAL(0)) u_a (
      .clk(clk), .reset(a_reset), .inc(a_inc), .dec(a_dec), .set(a_set), .new_val(a_nv),
      .Q(a_q), .at_max(a_max), .at_min(a_min), .carry(a_cy), .borrow(a_bw), .set_err(a_err));

   bcd_field_counter #(.NUM_DIGITS(2), .MIN_VAL(1), .MAX_VAL(12), .RESET_VAL(12)) u_b (
      .clk(clk), .reset(b_reset), .inc(b_inc), .dec(b_dec), .set(b_set), .new_val(b_nv),
      .Q(b_q), .at_max(b_max), .at_min(b_min), .carry(b_cy), .borrow(b_bw), .set_err(b_err));

   bcd_field_counter #(.NUM_DIGITS(2), .MIN_VAL(0), .MAX_VAL(59), .RESET_VAL(0)) u_sec (
      .clk(clk), .reset(c_reset), .inc(s_inc), .dec(s_dec), .set(s_set), .new_val(s_nv),
      .Q(s_q), .at_max(s_max), .at_min(s_min), .carry(s_cy), .borrow(s_bw), .set_err(s_err));

   bcd_field_counter #(.NUM_DIGITS(2), .MIN_VAL(0), .MAX_VAL(59), .RESET_VAL(0)) u_min (
      .clk(clk), .reset(c_reset), .inc(s_cy), .dec(s_bw), .set(m_set), .new_val(m_nv),
      .Q(m_q), .at_max(m_max), .at_min(m_min), .carry(m_cy), .borrow(m_bw), .set_err(m_err));

   // Reference state as plain decimal integers
   int ma, mb, ms, mm;
   bit ea, eb, es, em;

   function automatic int bcd2int(input logic [7:0] v);
      if (v[7:4] > 4'd9 || v[3:0] > 4'd9) return -1;
      return int'(v[7:4]) * 10 + int'(v[3:0]);
   endfunction

   function automatic logic [7:0] int2bcd(input int v);
      return {4'(v / 10), 4'(v % 10)};
   endfunction

   function automatic void ref_next(input int mn, input int mx, input int rv, input int cur,
                                    input bit rst, input bit st, input bit up, input bit dn,
                                    input logic [7:0] nv,
                                    output int nxt, output bit err, output bit cy, output bit bw);
      int n;
      nxt = cur; err = 1'b0; cy = 1'b0; bw = 1'b0;
      if (rst) begin
         nxt = rv;
      end else if (st) begin
         n = bcd2int(nv);
         if (n >= mn && n <= mx) nxt = n;
         else err = 1'b1;
      end else if (up && !dn) begin
         if (cur == mx) begin nxt = mn; cy = 1'b1; end
         else nxt = cur + 1;
      end else if (dn && !up) begin
         if (cur == mn) begin nxt = mx; bw = 1'b1; end
         else nxt = cur - 1;
      end
   endfunction

   // Inputs are already driven; check combinational outputs, clock once, check registered outputs.
   task automatic tick();
      int na, nb, ns, nm;
      bit xa, xb, xs, xm, ca, ba, cb, bb, cs, bs, cm, bm;
      #1;
      ref_next(0, 59, 0,  ma, a_reset, a_set, a_inc, a_dec, a_nv, na, xa, ca, ba);
      ref_next(1, 12, 12, mb, b_reset, b_set, b_inc, b_dec, b_nv, nb, xb, cb, bb);
      ref_next(0, 59, 0,  ms, c_reset, s_set, s_inc, s_dec, s_nv, ns, xs, cs, bs);
      ref_next(0, 59, 0,  mm, c_reset, m_set, cs,    bs,    m_nv, nm, xm, cm, bm);
      check("a_carry", a_cy, ca);   check("a_borrow", a_bw, ba);
      check("a_at_max", a_max, ma == 59); check("a_at_min", a_min, ma == 0);
      check("b_carry", b_cy, cb);   check("b_borrow", b_bw, bb);
      check("b_at_max", b_max, mb == 12); check("b_at_min", b_min, mb == 1);
      check("s_carry", s_cy, cs);   check("s_borrow", s_bw, bs);
      check("m_carry", m_cy, cm);   check("m_borrow", m_bw, bm);
      @(posedge clk);
      ma = na; mb = nb; ms = ns; mm = nm;
      ea = xa; eb = xb; es = xs; em = xm;
      #1;
      check("a_q", a_q, int2bcd(ma)); check("a_set_err", a_err, ea);
      check("b_q", b_q, int2bcd(mb)); check("b_set_err", b_err, eb);
      check("s_q", s_q, int2bcd(ms)); check("s_set_err", s_err, es);
      check("m_q", m_q, int2bcd(mm)); check("m_set_err", m_err, em);
   endtask

   task automatic idle_all();
      a_reset = 0; a_inc = 0; a_dec = 0; a_set = 0; a_nv = 8'h00;
      b_reset = 0; b_inc = 0; b_dec = 0; b_set = 0; b_nv = 8'h00;
      c_reset = 0; s_inc = 0; s_dec = 0; s_set = 0; m_set = 0; s_nv = 8'h00; m_nv = 8'h00;
   endtask

   function automatic logic [7:0] rand_nv(input int mn, input int mx);
      if ($urandom_range(0, 1) == 0) return int2bcd(int'($urandom_range(mn, mx)));
      return 8'($urandom);
   endfunction

   initial begin
      idle_all();
      a_reset = 1; b_reset = 1; c_reset = 1;
      @(posedge clk);
      #1;
      ma = 0; mb = 12; ms = 0; mm = 0;
      ea = 0; eb = 0; es = 0; em = 0;
      check("rst_a_q", a_q, 8'h00);  check("rst_a_err", a_err, 1'b0);
      check("rst_b_q", b_q, 8'h12);  check("rst_m_q", m_q, 8'h00);

      // Count 00..59 and wrap
      idle_all();
      for (int i = 0; i < 60; i++) begin
         a_inc = 1;
         tick();
      end
      check("a_wrap_up", a_q, 8'h00);

      // Down-wrap from 00 then plain decrement
      idle_all(); a_dec = 1; tick();
      check("a_wrap_down", a_q, 8'h59);
      tick();
      check("a_dec_58", a_q, 8'h58);

      // Valid and rejected loads
      idle_all(); a_set = 1; a_nv = 8'h47; tick();
      a_nv = 8'h60; tick();
      check("a_reject_range", a_err, 1'b1);
      a_nv = 8'h3A; tick();
      check("a_reject_digit", a_err, 1'b1);
      idle_all(); tick();
      check("a_err_pulse", a_err, 1'b0);
      check("a_hold_47", a_q, 8'h47);

      // Hours field 1..12
      idle_all(); b_inc = 1; tick();
      check("b_wrap_up", b_q, 8'h01);
      idle_all(); b_dec = 1; tick();
      check("b_wrap_down", b_q, 8'h12);
      idle_all(); b_set = 1; b_nv = 8'h00; tick();
      check("b_reject_00", b_err, 1'b1);

      // set beats inc at max; inc+dec holds
      idle_all(); a_set = 1; a_nv = 8'h59; tick();
      a_inc = 1; a_nv = 8'h10; tick();
      check("a_set_over_inc", a_q, 8'h10);
      idle_all(); a_inc = 1; a_dec = 1; tick();
      check("a_inc_dec_hold", a_q, 8'h10);

      // Chain 59:59 -> 00:00, then reset during inc
      idle_all(); s_set = 1; m_set = 1; s_nv = 8'h59; m_nv = 8'h59; tick();
      idle_all(); s_inc = 1;
      #1;
      check("chain_m_carry", m_cy, 1'b1);
      tick();
      check("chain_sec", s_q, 8'h00); check("chain_min", m_q, 8'h00);
      idle_all(); s_set = 1; m_set = 1; s_nv = 8'h59; m_nv = 8'h30; tick();
      idle_all(); c_reset = 1; s_inc = 1; tick();
      idle_all(); tick();

      // Randomised traffic on all fields
      for (int n = 0; n < 600; n++) begin
         a_reset = ($urandom_range(0, 31) == 0);
         a_set = ($urandom_range(0, 7) == 0); a_inc = 1'($urandom); a_dec = 1'($urandom);
         a_nv = rand_nv(0, 59);
         b_reset = ($urandom_range(0, 31) == 0);
         b_set = ($urandom_range(0, 7) == 0); b_inc = 1'($urandom); b_dec = 1'($urandom);
         b_nv = rand_nv(1, 12);
         c_reset = ($urandom_range(0, 63) == 0);
         s_set = ($urandom_range(0, 7) == 0); s_inc = 1'($urandom); s_dec = 1'($urandom);
         m_set = ($urandom_range(0, 7) == 0);
         s_nv = rand_nv(0, 59); m_nv = rand_nv(0, 59);
         tick();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
